// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hold/flush/redirect control for the 5-stage core.
// Sequences boot drain, resolves jumps, load-use and multi-cycle EX stalls.
module pipe_hazard_ctrl #(
    parameter int BOOT_CYCLES  = 4,
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        reboot_i,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        ex_busy_i,
    input  logic        ex_mem_rd_i,
    input  logic [4:0]  ex_rd_addr_i,
    input  logic        id_rs1_re_i,
    input  logic        id_rs2_re_i,
    input  logic [4:0]  id_rs1_addr_i,
    input  logic [4:0]  id_rs2_addr_i,
    output logic [2:0]  hold_flag_o,
    output logic        flush_if_o,
    output logic        flush_id_o,
    output logic        jump_flag_o,
    output logic [31:0] jump_addr_o,
    output logic        boot_done_o,
    output logic [31:0] stall_cnt_o,
    output logic        busy_err_o
);
    localparam int BW = $clog2(BOOT_CYCLES + 1);
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [BW-1:0] BOOT_LOAD = BW'(BOOT_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT   = TW'(BUSY_TIMEOUT);

    localparam logic [2:0] HOLD_NONE = 3'd0;
    localparam logic [2:0] HOLD_IF   = 3'd2;
    localparam logic [2:0] HOLD_ID   = 3'd3;

    typedef enum logic [1:0] {
        S_BOOT   = 2'd0,
        S_RUN    = 2'd1,
        S_EXWAIT = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [BW-1:0] boot_cnt;
    logic [TW-1:0] timer, timer_nx;
    logic          pend;
    logic [31:0]   pend_addr;
    logic [31:0]   stall_cnt;
    logic          err;

    logic boot_like, active, load_use;
    logic hold_busy, fresh_jump, pend_go, lu_stall;

    assign load_use = ex_mem_rd_i && (ex_rd_addr_i != 5'd0) &&
                      ((id_rs1_re_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                       (id_rs2_re_i && (id_rs2_addr_i == ex_rd_addr_i)));

    assign boot_like  = reboot_i || (state == S_BOOT);
    assign active     = !boot_like;
    assign hold_busy  = active && ex_busy_i;
    assign fresh_jump = active && !ex_busy_i && jump_flag_i;
    assign pend_go    = active && (state == S_EXWAIT) && !ex_busy_i &&
                        !jump_flag_i && pend;
    assign lu_stall   = active && !ex_busy_i && !jump_flag_i &&
                        !pend_go && load_use;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= S_BOOT;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_BOOT:   if (boot_cnt == '0) state_nx = S_RUN;
            S_RUN:    if (ex_busy_i) state_nx = S_EXWAIT;
            S_EXWAIT: if (!ex_busy_i) state_nx = S_RUN;
            default:  state_nx = S_BOOT;
        endcase
        if (reboot_i) state_nx = S_BOOT;
    end

    always_comb begin
        hold_flag_o = HOLD_NONE;
        flush_if_o  = 1'b0;
        flush_id_o  = 1'b0;
        jump_flag_o = 1'b0;
        jump_addr_o = 32'd0;
        unique case (1'b1)
            boot_like: begin
                hold_flag_o = HOLD_ID;
                flush_if_o  = 1'b1;
                flush_id_o  = 1'b1;
            end
            hold_busy: hold_flag_o = HOLD_ID;
            fresh_jump: begin
                jump_flag_o = 1'b1;
                jump_addr_o = jump_addr_i;
                flush_if_o  = 1'b1;
                flush_id_o  = 1'b1;
            end
            pend_go: begin
                jump_flag_o = 1'b1;
                jump_addr_o = pend_addr;
                flush_if_o  = 1'b1;
                flush_id_o  = 1'b1;
            end
            lu_stall: begin
                hold_flag_o = HOLD_IF;
                flush_id_o  = 1'b1;
            end
            default: ;
        endcase
    end

    // The first busy cycle (still in RUN) counts toward the timeout.
    always_comb begin
        timer_nx = '0;
        if (hold_busy) timer_nx = (timer == TIMEOUT) ? timer : timer + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            boot_cnt  <= BOOT_LOAD;
            timer     <= '0;
            pend      <= 1'b0;
            pend_addr <= 32'd0;
            stall_cnt <= 32'd0;
            err       <= 1'b0;
        end else begin
            timer <= timer_nx;
            if (timer_nx == TIMEOUT) err <= 1'b1;
            if ((state != S_BOOT) && (hold_flag_o != HOLD_NONE))
                stall_cnt <= stall_cnt + 32'd1;
            if (reboot_i) begin
                boot_cnt  <= BOOT_LOAD;
                pend      <= 1'b0;
                pend_addr <= 32'd0;
            end else begin
                if ((state == S_BOOT) && (boot_cnt != '0))
                    boot_cnt <= boot_cnt - 1'b1;
                if (hold_busy && jump_flag_i) begin
                    pend      <= 1'b1;
                    pend_addr <= jump_addr_i;
                end else if ((state == S_EXWAIT) && !ex_busy_i) begin
                    pend      <= 1'b0;
                    pend_addr <= 32'd0;
                end
            end
        end
    end

    assign boot_done_o = (state == S_RUN) || (state == S_EXWAIT);
    assign stall_cnt_o = stall_cnt;
    assign busy_err_o  = err;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl.
// Inputs change 1ns after each rising edge, outputs sampled 1ns later.
module tb_pipe_hazard_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reboot = 1'b0;
    logic        jflag = 1'b0;
    logic [31:0] jaddr = 32'd0;
    logic        busy = 1'b0;
    logic        memrd = 1'b0;
    logic [4:0]  rd = 5'd0;
    logic        rs1_re = 1'b0;
    logic        rs2_re = 1'b0;
    logic [4:0]  rs1 = 5'd0;
    logic [4:0]  rs2 = 5'd0;

    logic [2:0]  hold;
    logic        fif, fid, jf, bd, err;
    logic [31:0] ja, stall;

    int checks = 0;
    int errors = 0;

    pipe_hazard_ctrl #(.BOOT_CYCLES(4), .BUSY_TIMEOUT(64)) dut (
        .clk_i(clk), .rst_ni(rst_n), .reboot_i(reboot),
        .jump_flag_i(jflag), .jump_addr_i(jaddr), .ex_busy_i(busy),
        .ex_mem_rd_i(memrd), .ex_rd_addr_i(rd),
        .id_rs1_re_i(rs1_re), .id_rs2_re_i(rs2_re),
        .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
        .hold_flag_o(hold), .flush_if_o(fif), .flush_id_o(fid),
        .jump_flag_o(jf), .jump_addr_o(ja), .boot_done_o(bd),
        .stall_cnt_o(stall), .busy_err_o(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reboot = 0; jflag = 0; jaddr = 0; busy = 0; memrd = 0;
        rd = 0; rs1_re = 0; rs2_re = 0; rs1 = 0; rs2 = 0;
    endtask

    task automatic boot_seq(input string tag, input int exp_stall);
        for (int i = 1; i <= 3; i++) begin
            step(); #1;
            check({tag, "_bd0"}, 32'(bd), 32'd0);
            check({tag, "_hold3"}, 32'(hold), 32'd3);
            check({tag, "_jf0"}, 32'(jf), 32'd0);
        end
        step(); #1;
        check({tag, "_bd1"}, 32'(bd), 32'd1);
        check({tag, "_hold0"}, 32'(hold), 32'd0);
        check({tag, "_jf_exit"}, 32'(jf), 32'd0);
        check({tag, "_stall"}, stall, 32'(exp_stall));
    endtask

    initial begin
        idle();
        step(); step(); #1;
        check("rst_hold", 32'(hold), 32'd3);
        check("rst_fif", 32'(fif), 32'd1);
        check("rst_fid", 32'(fid), 32'd1);
        check("rst_jf", 32'(jf), 32'd0);
        check("rst_ja", ja, 32'd0);
        check("rst_bd", 32'(bd), 32'd0);
        check("rst_stall", stall, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1;
        boot_seq("boot", 0);

        // taken jump in RUN
        step();
        jflag = 1; jaddr = 32'h100; #1;
        check("jmp_jf", 32'(jf), 32'd1);
        check("jmp_ja", ja, 32'h100);
        check("jmp_fif", 32'(fif), 32'd1);
        check("jmp_fid", 32'(fid), 32'd1);
        check("jmp_hold", 32'(hold), 32'd0);

        // load-use on rs2
        step(); idle();
        memrd = 1; rd = 5; rs2_re = 1; rs2 = 5; #1;
        check("lu_hold", 32'(hold), 32'd2);
        check("lu_fid", 32'(fid), 32'd1);
        check("lu_fif", 32'(fif), 32'd0);
        check("lu_ja", ja, 32'd0);
        step(); idle();
        memrd = 1; rd = 0; rs2_re = 1; rs2 = 0; #1;
        check("lu_x0_hold", 32'(hold), 32'd0);
        check("lu_x0_fid", 32'(fid), 32'd0);
        step(); idle();
        memrd = 1; rd = 7; rs1_re = 0; rs1 = 7; #1;
        check("lu_nore_hold", 32'(hold), 32'd0);
        check("lu_stall", stall, 32'd1);

        // busy 3 cycles, jump latched on the first
        step(); idle();
        busy = 1; jflag = 1; jaddr = 32'h200; #1;
        check("bz1_hold", 32'(hold), 32'd3);
        check("bz1_jf", 32'(jf), 32'd0);
        step(); idle(); busy = 1; #1;
        check("bz2_hold", 32'(hold), 32'd3);
        step(); idle(); busy = 1; #1;
        check("bz3_hold", 32'(hold), 32'd3);
        check("bz3_fid", 32'(fid), 32'd0);
        step(); idle(); #1;
        check("bz_stall", stall, 32'd4);
        check("bz_pend_jf", 32'(jf), 32'd1);
        check("bz_pend_ja", ja, 32'h200);
        check("bz_pend_fif", 32'(fif), 32'd1);
        check("bz_pend_hold", 32'(hold), 32'd0);
        step(); #1;
        check("bz_after_jf", 32'(jf), 32'd0);
        check("bz_after_bd", 32'(bd), 32'd1);

        // busy 70 cycles: timeout flag after the 64th edge
        for (int i = 1; i <= 70; i++) begin
            busy = 1; #1;
            if (i == 64) check("to_pre", 32'(err), 32'd0);
            if (i == 65) check("to_set", 32'(err), 32'd1);
            step();
        end
        idle(); #1;
        check("to_drop", 32'(err), 32'd1);
        check("to_stall", stall, 32'd74);
        check("to_jf", 32'(jf), 32'd0);

        // reboot mid-EXWAIT with pending jump
        step();
        busy = 1; jflag = 1; jaddr = 32'h300;
        step(); idle(); busy = 1;
        step(); #1;
        check("rb_pre_stall", stall, 32'd76);
        reboot = 1; #1;
        check("rb_hold", 32'(hold), 32'd3);
        check("rb_jf", 32'(jf), 32'd0);
        step(); idle(); #1;
        check("rb_boot_hold", 32'(hold), 32'd3);
        check("rb_boot_bd", 32'(bd), 32'd0);
        check("rb_err", 32'(err), 32'd1);
        check("rb_stall", stall, 32'd77);
        // reboot again while in BOOT restarts the count
        step(); step();
        reboot = 1;
        step(); idle(); #1;
        check("rb2_bd", 32'(bd), 32'd0);
        step(); step(); step(); #1;
        check("rb2_still_boot", 32'(bd), 32'd0);
        step(); #1;
        check("rb2_done", 32'(bd), 32'd1);
        check("rb2_nojmp", 32'(jf), 32'd0);
        check("rb2_stall", stall, 32'd77);
        check("rb2_err", 32'(err), 32'd1);

        // async reset mid-EXWAIT drops pending jump and clears flags
        busy = 1; jflag = 1; jaddr = 32'h400;
        step(); idle(); busy = 1;
        step();
        #2 rst_n = 0; #1;
        check("ar_hold", 32'(hold), 32'd3);
        check("ar_stall", stall, 32'd0);
        check("ar_err", 32'(err), 32'd0);
        idle();
        step(); #1;
        rst_n = 1;
        boot_seq("ar_boot", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got 0 exp 1");
        $fatal(1, "bench timeout");
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline control unit for the 5-stage RISC-V core. Sits beside `if_stage`/`id_stage`/`ex_stage` and decides, every cycle, which pipeline registers hold, which are flushed, and whether the PC is redirected. Sources: jump requests from EX, load-use hazards between ID and EX, multi-cycle EX operations, and reboot. Also sequences the post-reset/reboot drain, counts stall cycles, and flags a hung EX unit.

## Interface
Parameters:
- BOOT_CYCLES, 4: cycles the pipeline is held and flushed after reset or reboot (≥1).
- BUSY_TIMEOUT, 64: consecutive `ex_busy_i` cycles that set `busy_err_o` (≥2).

Ports:
- clk_i  in  1  core clock, all state on rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- reboot_i  in  1  synchronous restart request.
- jump_flag_i  in  1  EX resolved taken branch/jump.
- jump_addr_i  in  32  target for `jump_flag_i`.
- ex_busy_i  in  1  EX multi-cycle op in progress.
- ex_mem_rd_i  in  1  instruction in EX is a load.
- ex_rd_addr_i  in  5  EX destination register.
- id_rs1_re_i, id_rs2_re_i  in  1 each  ID reads rs1/rs2.
- id_rs1_addr_i, id_rs2_addr_i  in  5 each  ID source registers.
- hold_flag_o  out  3  0=NONE, 1=PC, 2=IF (PC+IF/ID), 3=ID (PC+IF/ID+ID/EX).
- flush_if_o  out  1  clear IF/ID to NOP next edge.
- flush_id_o  out  1  clear ID/EX to NOP next edge.
- jump_flag_o  out  1  PC redirect this cycle.
- jump_addr_o  out  32  redirect target (0 when `jump_flag_o`=0).
- boot_done_o  out  1  high in RUN/EXWAIT.
- stall_cnt_o  out  32  hold-cycle counter.
- busy_err_o  out  1  sticky EX-timeout flag.

## Operation
- FSM states: BOOT, RUN, EXWAIT. Registers: state, boot counter, busy timer, jump-pending flag + 32-bit pending address, stall counter, error flag.
- BOOT: hold=3, flush_if=flush_id=1, jump outputs 0, all inputs ignored. Counter loads BOOT_CYCLES-1, decrements; at 0 → RUN.
- `reboot_i` in any state, priority over everything: next state BOOT, counter reloaded, pending jump cleared, busy timer cleared. Stall counter and error flag kept.
- RUN, priority high→low:
  1. `jump_flag_i` && !`ex_busy_i`: jump_flag_o=1, jump_addr_o=jump_addr_i, flush_if=flush_id=1, hold=0.
  2. `ex_busy_i`: hold=3, no flush. If `jump_flag_i` also high, latch pending jump (flag+addr). Next state EXWAIT.
  3. Load-use: `ex_mem_rd_i` && `ex_rd_addr_i`≠0 && ((rs1_re && rs1==rd) || (rs2_re && rs2==rd)): hold=2, flush_id=1 (bubble).
  4. Else hold=0, no flush.
- EXWAIT:
  - `ex_busy_i`=1: hold=3. Busy timer increments, saturating. Set `busy_err_o` when timer reaches BUSY_TIMEOUT. A `jump_flag_i` here overwrites the pending jump.
  - `ex_busy_i`=0: next state RUN, timer cleared.
    - Fresh `jump_flag_i` this cycle: drive it; pending cleared.
    - Else pending jump set: drive pending address with flush_if=flush_id=1; pending cleared.
    - Else apply the RUN rules 3–4.
- `stall_cnt_o` increments (32-bit wrap) on every cycle with hold_flag_o≠0 in RUN or EXWAIT; never in BOOT.
- `busy_err_o` is cleared only by `rst_ni`.

## Timing
- Reset values: state BOOT, boot counter BOOT_CYCLES-1, hold_flag_o=3, flush_if_o=flush_id_o=1, jump_flag_o=0, jump_addr_o=0, boot_done_o=0, stall_cnt_o=0, busy_err_o=0, pending cleared.
- Timing of outputs:
  - After reset release, BOOT lasts exactly BOOT_CYCLES clock edges, then boot_done_o=1.
  - All hold/flush/jump outputs are combinational from the current state and inputs: zero-cycle latency. Stages act on the next edge.
  - Pending jump issues in the first cycle `ex_busy_i` is low, never later.
- Boundary cases:
  - `reboot_i` while already in BOOT restarts the count.
  - Reset mid-EXWAIT drops the pending jump.
  - A load-use hazard with rd=x0 is never a hazard.
  - Timer saturates at BUSY_TIMEOUT; no wrap.

## Test plan
- Reset with BOOT_CYCLES=4 → hold=3 and both flushes for 4 edges, then boot_done_o=1 and hold=0; stall_cnt_o=0.
- RUN, `jump_flag_i`=1, addr 0x0000_0100 → same cycle jump_flag_o=1, jump_addr_o=0x100, flush_if=flush_id=1, hold=0.
- Load-use: EX load rd=5, ID rs2=5 with rs2_re=1 → hold=2, flush_id=1 for one cycle. Repeat with rd=0 → hold=0.
- `ex_busy_i` high 3 cycles with jump to 0x200 on its first cycle → hold=3 ×3, stall_cnt_o=3. On the cycle busy drops: jump_flag_o=1, jump_addr_o=0x200, state RUN.
- `ex_busy_i` held 70 cycles, BUSY_TIMEOUT=64 → busy_err_o rises on the 64th cycle and stays high after busy drops and after `reboot_i`.
- `reboot_i` mid-EXWAIT with pending jump → next cycle BOOT (hold=3, boot_done_o=0). No jump issued on exit; stall_cnt_o retained.
